mac_array_ctrl: RTL and testbench

Sequencer for the ROW×COLUMN systolic MAC array. Per job it loads one weight vector into each array row via `w_en`, then streams activation vectors into the array with per-row skew. It also generates valid/first/last sideband aligned to the array's `mac_s_data`, and drains the pipeline. It sits between the conv feature/weight buffers (stream sources) and the `mac` array instance, and is the array's only driver.

---
 rtl/mac_array_ctrl.sv | 143 ++++++++++++++
 tb/tb_mac_array_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_array_ctrl.sv
// mac_array_ctrl: loads ROW weight rows, then streams skewed activations into the MAC array with aligned sideband.
// An accepted beat reaches o_valid ROW+LAT cycles later; readies decode state only and stalls become o_valid bubbles.
module mac_array_ctrl #(
   parameter int DW     = 8,
   parameter int ROW    = 7,
   parameter int COLUMN = 7,
   parameter int LAT    = 1,
   parameter int LEN_W  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_start,
   input  logic [LEN_W-1:0]      cfg_len,
   input  logic                  w_s_valid,
   output logic                  w_s_ready,
   input  logic [COLUMN*DW-1:0]  w_s_data,
   input  logic                  x_s_valid,
   output logic                  x_s_ready,
   input  logic [ROW*DW-1:0]     x_s_data,
   output logic [COLUMN*DW-1:0]  w,
   output logic [ROW-1:0]        w_en,
   output logic [ROW*DW-1:0]     mac_m_data,
   output logic                  o_valid,
   output logic                  o_first,
   output logic                  o_last,
   output logic                  busy,
   output logic                  done
);

   localparam int D  = ROW + LAT;
   localparam int CW = $clog2(D + 1);
   localparam logic [CW-1:0]    K_LAST = CW'(ROW - 1);
   localparam logic [CW-1:0]    D_LAST = CW'(D - 1);
   localparam logic [LEN_W-1:0] ONE    = LEN_W'(1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t           state;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] beat;
   logic [CW-1:0]    k;
   logic [CW-1:0]    dcnt;
   logic             x_acc;
   logic [2:0]       tok [0:D-1];

   assign w_s_ready = (state == S_LOAD_W);
   assign x_s_ready = (state == S_RUN);
   assign x_acc     = x_s_ready && x_s_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         len_q <= '0;
         beat  <= '0;
         k     <= '0;
         dcnt  <= '0;
         w     <= '0;
         w_en  <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         w_en <= '0;
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cfg_start) begin
                  len_q <= cfg_len;
                  k     <= '0;
                  beat  <= '0;
                  busy  <= 1'b1;
                  state <= S_LOAD_W;
               end
            end
            S_LOAD_W: begin
               if (w_s_valid) begin
                  w    <= w_s_data;
                  w_en <= ROW'(1) << k;
                  if (k == K_LAST) begin
                     k     <= '0;
                     dcnt  <= '0;
                     state <= (len_q == '0) ? S_DRAIN : S_RUN;
                  end else begin
                     k <= k + CW'(1);
                  end
               end
            end
            S_RUN: begin
               if (x_s_valid) begin
                  if (beat == len_q - ONE) begin
                     beat  <= '0;
                     dcnt  <= '0;
                     state <= S_DRAIN;
                  end else begin
                     beat <= beat + ONE;
                  end
               end
            end
            S_DRAIN: begin
               if (dcnt == D_LAST) begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  dcnt <= dcnt + CW'(1);
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Lane r gets r+1 stages so each array row sees its operand one cycle after the row above.
   for (genvar r = 0; r < ROW; r++) begin : g_lane
      logic [DW-1:0] pipe [0:r];
      always_ff @(posedge clk) begin
         if (rst) begin
            for (int s = 0; s <= r; s++) pipe[s] <= '0;
         end else begin
            pipe[0] <= x_acc ? x_s_data[r*DW +: DW] : '0;
            for (int s = 1; s <= r; s++) pipe[s] <= pipe[s-1];
         end
      end
      assign mac_m_data[r*DW +: DW] = pipe[r];
   end

   // Stall cycles enter as all-zero tokens, so bubbles keep their place in the beat order.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < D; i++) tok[i] <= '0;
      end else begin
         tok[0] <= {x_acc, x_acc && (beat == '0), x_acc && (beat == len_q - ONE)};
         for (int i = 1; i < D; i++) tok[i] <= tok[i-1];
      end
   end

   assign o_valid = tok[D-1][2];
   assign o_first = tok[D-1][1];
   assign o_last  = tok[D-1][0];

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Randomized bench for mac_array_ctrl: driver pushes expected events into queues, a negedge monitor pops and compares.
module tb_mac_array_ctrl;

   localparam int DW = 8, ROW = 7, COLUMN = 7, LAT = 1, LEN_W = 16;

   logic                 clk = 1'b0;
   logic                 rst, cfg_start, w_s_valid, x_s_valid;
   logic [LEN_W-1:0]     cfg_len;
   logic [COLUMN*DW-1:0] w_s_data, w;
   logic [ROW*DW-1:0]    x_s_data, mac_m_data;
   logic [ROW-1:0]       w_en;
   logic                 w_s_ready, x_s_ready, o_valid, o_first, o_last, busy, done;

   mac_array_ctrl #(.DW(DW), .ROW(ROW), .COLUMN(COLUMN), .LAT(LAT), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_len(cfg_len),
      .w_s_valid(w_s_valid), .w_s_ready(w_s_ready), .w_s_data(w_s_data),
      .x_s_valid(x_s_valid), .x_s_ready(x_s_ready), .x_s_data(x_s_data),
      .w(w), .w_en(w_en), .mac_m_data(mac_m_data),
      .o_valid(o_valid), .o_first(o_first), .o_last(o_last), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {int cyc; bit first; bit last;} oexp_t;
   typedef struct {int cyc; logic [COLUMN*DW-1:0] dat; logic [ROW-1:0] en;} wexp_t;

   oexp_t             oq [$];
   wexp_t             wq [$];
   int                dq [$];
   logic [ROW*DW-1:0] xhist [int];   // accepted activation vector per cycle

   int cyc = 0, n_tests = 0, n_fail = 0, o_cnt = 0;
   int phase = 0;                    // 1: weight load, 2: activation run
   int busy_lo = 1, busy_hi = 0, flush_mark = -1000;
   bit chk_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic monitor_cycle();
      logic [ROW*DW-1:0] ev;
      oexp_t oe;
      wexp_t we;
      int    a;
      ev = '0;
      for (int r = 0; r < ROW; r++) begin
         a = cyc - r - 1;
         if (xhist.exists(a) && !(a < flush_mark && cyc > flush_mark))
            ev[r*DW +: DW] = xhist[a][r*DW +: DW];
      end
      chk("mac_m_data", 64'(mac_m_data), 64'(ev));
      chk("w_s_ready", 64'(w_s_ready), 64'(phase == 1));
      chk("x_s_ready", 64'(x_s_ready), 64'(phase == 2));
      chk("busy", 64'(busy), 64'(cyc >= busy_lo && cyc <= busy_hi));
      if (o_valid) begin
         o_cnt++;
         if (oq.size() == 0) chk("o_valid_unexpected", 64'd1, 64'd0);
         else begin
            oe = oq.pop_front();
            chk("o_valid_cycle", 64'(cyc), 64'(oe.cyc));
            chk("o_first", 64'(o_first), 64'(oe.first));
            chk("o_last", 64'(o_last), 64'(oe.last));
         end
      end else begin
         chk("o_sideband_idle", 64'({o_first, o_last}), 64'd0);
         if (oq.size() > 0 && oq[0].cyc <= cyc) begin
            chk("o_valid_missing", 64'd0, 64'd1);
            void'(oq.pop_front());
         end
      end
      if (w_en != '0) begin
         if (wq.size() == 0) chk("w_en_unexpected", 64'(w_en), 64'd0);
         else begin
            we = wq.pop_front();
            chk("w_en_cycle", 64'(cyc), 64'(we.cyc));
            chk("w_en", 64'(w_en), 64'(we.en));
            chk("w", 64'(w), 64'(we.dat));
         end
      end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
         chk("w_en_missing", 64'(w_en), 64'(wq[0].en));
         void'(wq.pop_front());
      end
      if (done) begin
         if (dq.size() == 0) chk("done_unexpected", 64'd1, 64'd0);
         else chk("done_cycle", 64'(cyc), 64'(dq.pop_front()));
      end else if (dq.size() > 0 && dq[0] <= cyc) begin
         chk("done_missing", 64'd0, 64'd1);
         void'(dq.pop_front());
      end
   endtask

   always @(negedge clk) if (chk_en) monitor_cycle();

   task automatic do_abort();
      int n, o_before;
      n = cyc;
      rst = 1'b1; x_s_valid = 1'b0; w_s_valid = 1'b0; cfg_start = 1'b0;
      flush_mark = n;
      busy_hi = n;
      while (oq.size() > 0 && oq[$].cyc > n) void'(oq.pop_back());
      while (wq.size() > 0 && wq[$].cyc > n) void'(wq.pop_back());
      while (dq.size() > 0 && dq[$] > n) void'(dq.pop_back());
      tick();
      phase = 0;
      @(negedge clk);
      chk("rst_outputs_zero", (|{w, w_en, mac_m_data, o_valid, o_first, o_last, busy, done,
                                 w_s_ready, x_s_ready}) ? 64'd1 : 64'd0, 64'd0);
      o_before = o_cnt;
      tick();
      tick();
      rst = 1'b0;
      repeat (20) tick();
      chk("o_valid_after_rst", 64'(o_cnt - o_before), 64'd0);
   endtask

   task automatic run_job(input int len, input int pct, input int gap_after, input int gap_len,
                          input bit wdir, input bit xdir, input bit poke, input int abort_at);
      int k, b, gap_left, last_cyc, done_cyc;
      logic [63:0] rnd;
      cfg_start = 1'b1;
      cfg_len   = LEN_W'(len);
      busy_lo   = cyc + 1;
      busy_hi   = 1 << 30;
      tick();
      cfg_start = 1'b0;
      cfg_len   = LEN_W'($urandom);
      phase = 1;
      k = 0;
      last_cyc = cyc;
      while (k < ROW) begin
         rnd = {$urandom, $urandom};
         w_s_data  = rnd[COLUMN*DW-1:0];
         w_s_valid = ($urandom_range(99) >= pct);
         if (wdir) begin
            w_s_valid = 1'b1;
            for (int c = 0; c < COLUMN; c++) w_s_data[c*DW +: DW] = DW'(k + 1);
         end
         if (w_s_valid) begin
            wq.push_back('{cyc + 1, w_s_data, ROW'(1) << k});
            last_cyc = cyc;
            k++;
         end
         tick();
      end
      w_s_valid = 1'b0;
      phase = (len > 0) ? 2 : 0;
      b = 0;
      gap_left = 0;
      while (b < len) begin
         if (b == abort_at) begin
            do_abort();
            return;
         end
         cfg_start = poke && (b >= 1);
         if (gap_left > 0) begin
            x_s_valid = 1'b0;
            gap_left--;
         end else begin
            x_s_valid = ($urandom_range(99) >= pct);
         end
         rnd = {$urandom, $urandom};
         x_s_data = rnd[ROW*DW-1:0];
         if (xdir) for (int r = 0; r < ROW; r++) x_s_data[r*DW +: DW] = DW'(r * 16 + b);
         if (x_s_valid) begin
            xhist[cyc] = x_s_data;
            oq.push_back('{cyc + ROW + LAT, b == 0, b == len - 1});
            last_cyc = cyc;
            if (b == gap_after) gap_left = gap_len;
            b++;
         end
         tick();
      end
      x_s_valid = 1'b0;
      cfg_start = 1'b0;
      phase = 0;
      done_cyc = last_cyc + ROW + LAT + 1;
      dq.push_back(done_cyc);
      busy_hi = done_cyc;
      while (cyc <= done_cyc + 1) tick();
   endtask

   initial begin
      rst = 1'b1; cfg_start = 1'b0; cfg_len = '0;
      w_s_valid = 1'b0; w_s_data = '0; x_s_valid = 1'b0; x_s_data = '0;
      repeat (3) tick();
      rst = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      chk("reset_outputs_zero", (|{w, w_en, mac_m_data, o_valid, o_first, o_last, busy, done,
                                   w_s_ready, x_s_ready}) ? 64'd1 : 64'd0, 64'd0);
      tick();
      run_job(4, 0, -1, 0, 1'b1, 1'b0, 1'b0, -1);   // directed weights, latency/sideband
      run_job(3, 0, -1, 0, 1'b0, 1'b1, 1'b0, -1);   // lane-tagged skew
      run_job(4, 0, 1, 2, 1'b0, 1'b0, 1'b0, -1);    // two-cycle stall after beat 1
      run_job(1, 0, -1, 0, 1'b0, 1'b0, 1'b0, -1);
      run_job(0, 0, -1, 0, 1'b0, 1'b0, 1'b0, -1);
      run_job(6, 20, -1, 0, 1'b0, 1'b0, 1'b1, -1);  // cfg_start pulsed during RUN
      run_job(10, 10, -1, 0, 1'b0, 1'b0, 1'b0, 4);  // reset mid-RUN
      run_job(2, 0, -1, 0, 1'b0, 1'b0, 1'b0, -1);
      repeat (12) begin
         run_job($urandom_range(12), $urandom_range(40), -1, 0, 1'b0, 1'b0,
                 1'($urandom_range(1)), -1);
         repeat ($urandom_range(3)) tick();
      end
      repeat (5) tick();
      chk("o_queue_empty", 64'(oq.size()), 64'd0);
      chk("w_queue_empty", 64'(wq.size()), 64'd0);
      chk("done_queue_empty", 64'(dq.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
